uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; `clk` and `rst` SHALL be the only clock and reset ports.
REQ-002 The block SHALL have parameter: CLKS_PER_BIT, default 434, meaning clk cycles per serial bit.
REQ-003 The block SHALL have ports in this positional order: rst, data_in, wr_en, clk, ready_clr, ready, busy, data_out.
REQ-004 Port: clk  input  1  rising-edge system clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: data_in  input  8  byte to transmit, sampled on the accept edge.
REQ-007 Port: wr_en  input  1  transmit request, one-cycle pulse.
REQ-008 Port: ready_clr  input  1  clears ready.
REQ-009 Port: ready  output  1  received byte valid, sticky.
REQ-010 Port: busy  output  1  transmitter frame in progress.
REQ-011 Port: data_out  output  8  last received byte.

Function
REQ-012 The block SHALL contain a UART transmitter and receiver; the internal serial line (tx) SHALL be looped back directly to the receiver input; the serial line is not a port.
REQ-013 Frame format SHALL be 8N1: start bit 0, eight data bits LSB first, one stop bit 1, each bit CLKS_PER_BIT cycles; the line SHALL idle at 1.
REQ-014 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 In IDLE, wr_en=1 at a rising edge SHALL latch data_in, enter START and drive tx=0; busy SHALL be 1 from the next cycle.
REQ-016 wr_en while busy=1 SHALL be ignored (no queuing, latched byte unchanged).
REQ-017 busy SHALL stay 1 through the full stop bit and return to 0 exactly 10*CLKS_PER_BIT cycles after accept; a new wr_en SHALL be accepted in that same cycle.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, STOP; RX SHALL sample the line directly (same clock domain, no synchronizer).
REQ-019 In IDLE, rx=0 SHALL enter START; after CLKS_PER_BIT/2 cycles rx still 0 SHALL continue, otherwise return to IDLE (glitch reject).
REQ-020 RX SHALL then sample each data bit every CLKS_PER_BIT cycles at mid-bit, shifting LSB first.
REQ-021 At the mid-stop-bit sample, data_out SHALL load the shift register and ready SHALL be set to 1; this occurs before busy falls.
REQ-022 A stop-bit sample of 0 SHALL still load data_out and set ready (no framing-error output).
REQ-023 ready SHALL remain 1 until ready_clr=1 at a rising edge, then be 0 on the next cycle.
REQ-024 When a byte completes in the same cycle as ready_clr, ready SHALL be set (completion wins).
REQ-025 A new byte completing while ready=1 SHALL overwrite data_out (no overrun flag).

Reset
REQ-026 rst SHALL put both FSMs in IDLE with tx=1, busy=0, ready=0, data_out=8'h00, and all counters and shift registers at 0.
REQ-027 rst mid-frame SHALL abort transmit and receive immediately; data_out/ready SHALL NOT update from the aborted frame.

Structure
REQ-028 A shared package SHALL hold the TX/RX state enum typedefs and the default CLKS_PER_BIT constant.
REQ-029 One sub-module, uart_tx, containing the TX FSM, bit counter and baud counter, SHALL be instantiated; the RX logic and loopback SHALL reside in uart_top.

Verification
REQ-030 Reset, then send 8'h25 -> busy high next cycle and low after 4340 cycles; ready=1 before busy falls; data_out=8'h25.
REQ-031 Pulse ready_clr, then send 8'h77 -> ready=0 after the clear; after the frame, ready=1 and data_out=8'h77.
REQ-032 Send 8'hA5, then pulse wr_en with 8'h3C mid-frame -> data_out=8'hA5 only, and busy falls at 4340 cycles.
REQ-033 Send back-to-back 8'h00 and 8'hFF with no ready_clr -> ready stays 1 and data_out ends at 8'hFF.
REQ-034 Assert rst midway through 8'h5A -> tx=1, busy=0, ready=0, data_out=8'h00, and no later update; a following 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the looped-back UART: FSM state encodings and
// the default baud divisor.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on wr_en while idle and serialises it
// LSB first; busy covers the whole frame including the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t        state_r, state_n;
  logic [CNT_W-1:0] baud_r, baud_n;
  logic [2:0]       bit_r, bit_n;
  logic [7:0]       data_r, data_n;
  logic             tx_r, tx_n;
  logic             busy_r, busy_n;
  logic             baud_last_s;

  assign baud_last_s = (baud_r == CNT_W'(CLKS_PER_BIT - 1));
  assign tx          = tx_r;
  assign busy        = busy_r;

  // State and output registers; tx and busy are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TX_IDLE;
      baud_r  <= {CNT_W{1'b0}};
      bit_r   <= 3'd0;
      data_r  <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      baud_r  <= baud_n;
      bit_r   <= bit_n;
      data_r  <= data_n;
      tx_r    <= tx_n;
      busy_r  <= busy_n;
    end
  end

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles, wr_en is only seen in IDLE.
  always_comb begin
    state_n = state_r;
    baud_n  = baud_r;
    bit_n   = bit_r;
    data_n  = data_r;
    tx_n    = tx_r;
    busy_n  = busy_r;
    case (state_r)
      TX_IDLE: begin
        if (wr_en) begin
          state_n = TX_START;
          baud_n  = {CNT_W{1'b0}};
          bit_n   = 3'd0;
          data_n  = data_in;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end else begin
          tx_n   = 1'b1;
          busy_n = 1'b0;
        end
      end
      TX_START: begin
        if (baud_last_s) begin
          state_n = TX_DATA;
          baud_n  = {CNT_W{1'b0}};
          tx_n    = data_r[0];
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_last_s) begin
          baud_n = {CNT_W{1'b0}};
          if (bit_r == 3'd7) begin
            state_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_r + 3'd1;
            tx_n  = data_r[bit_r + 3'd1];
          end
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      TX_STOP: begin
        // busy drops on the edge that ends the stop bit, so IDLE can accept the next byte at once.
        if (baud_last_s) begin
          state_n = TX_IDLE;
          baud_n  = {CNT_W{1'b0}};
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = TX_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_top.sv
// UART with the transmitter looped straight back into an on-chip receiver;
// the receiver exposes the last byte and a sticky ready flag.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       clk,
  input  logic       ready_clr,
  output logic       ready,
  output logic       busy,
  output logic [7:0] data_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             tx_line_s;
  rx_state_t        rx_state_r, rx_state_n;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_n;
  logic [2:0]       rx_bit_r, rx_bit_n;
  logic [7:0]       rx_shift_r, rx_shift_n;
  logic [7:0]       data_out_r, data_out_n;
  logic             ready_r, ready_n;
  logic             rx_done_s;
  logic             rx_half_s;
  logic             rx_last_s;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .data_in(data_in),
    .tx     (tx_line_s),
    .busy   (busy)
  );

  assign rx_half_s = (rx_cnt_r == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign rx_last_s = (rx_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign ready     = ready_r;
  assign data_out  = data_out_r;

  // Receiver state, sample shift register and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= {CNT_W{1'b0}};
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      data_out_r <= 8'h00;
      ready_r    <= 1'b0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
      data_out_r <= data_out_n;
      ready_r    <= ready_n;
    end
  end

  // Receiver next-state: qualify the start bit at half a bit, then sample at mid-bit.
  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    data_out_n = data_out_r;
    rx_done_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_n = {CNT_W{1'b0}};
        if (tx_line_s == 1'b0) begin
          rx_state_n = RX_START;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_half_s) begin
          rx_cnt_n = {CNT_W{1'b0}};
          if (tx_line_s == 1'b0) begin
            rx_state_n = RX_DATA;
            rx_bit_n   = 3'd0;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_last_s) begin
          rx_cnt_n   = {CNT_W{1'b0}};
          rx_shift_n = {tx_line_s, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // The stop-bit value is not inspected: a bad stop bit still delivers the byte.
        if (rx_last_s) begin
          rx_state_n = RX_IDLE;
          rx_cnt_n   = {CNT_W{1'b0}};
          data_out_n = rx_shift_r;
          rx_done_s  = 1'b1;
        end else begin
          rx_cnt_n = rx_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = {CNT_W{1'b0}};
      end
    endcase

    if (rx_done_s) begin
      ready_n = 1'b1;
    end else if (ready_clr) begin
      ready_n = 1'b0;
    end else begin
      ready_n = ready_r;
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: frame timing, loopback data, sticky ready,
// ignored writes while busy, mid-frame reset and randomised bytes.
module tb_uart_top;

  localparam int N     = 434;
  localparam int FRAME = 10 * N;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       ready_clr;
  logic       ready;
  logic       busy;
  logic [7:0] data_out;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_data;
  logic       exp_ready;

  always #5 clk = ~clk;

  uart_top #(.CLKS_PER_BIT(N)) dut (
    .rst      (rst),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .clk      (clk),
    .ready_clr(ready_clr),
    .ready    (ready),
    .busy     (busy),
    .data_out (data_out)
  );

  // Sends one byte and follows the frame until busy falls (bounded).
  task automatic send_frame(input logic [7:0] b, input bit inject, input logic [7:0] junk,
                            input bit hold_clr, output bit busy_rose, output int cyc,
                            output bit rdy_early, output bit rdy_seen);
    @(negedge clk);
    data_in   = b;
    wr_en     = 1'b1;
    ready_clr = hold_clr;
    @(posedge clk); #1;
    wr_en     = 1'b0;
    data_in   = 8'h00;
    busy_rose = (busy === 1'b1);
    cyc       = 0;
    rdy_early = 1'b0;
    rdy_seen  = 1'b0;
    while (busy === 1'b1 && cyc < FRAME + 50) begin
      if (inject && cyc == 2000) begin
        wr_en   = 1'b1;
        data_in = junk;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (busy === 1'b1 && ready === 1'b1 && data_out === b) rdy_early = 1'b1;
      if (ready === 1'b1) rdy_seen = 1'b1;
    end
    wr_en     = 1'b0;
    ready_clr = 1'b0;
    exp_data  = b;
    exp_ready = !hold_clr;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    ready_clr = 1'b1;
    @(posedge clk); #1;
    ready_clr = 1'b0;
    exp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; ready_clr = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0;
    checks++;
    if (dut.tx_line_s !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got tx=%b busy=%b ready=%b data_out=%h exp tx=1 busy=0 ready=0 data_out=00",
               dut.tx_line_s, busy, ready, data_out);
    end
  endtask

  task automatic test_basic(input logic [7:0] b, input string name);
    bit rose, early, seen; int cyc;
    send_frame(b, 1'b0, 8'h00, 1'b0, rose, cyc, early, seen);
    checks++;
    if (!rose) begin failures++; $display("FAIL %s_busy_rise got=0 exp=1", name); end
    checks++;
    if (cyc != FRAME) begin failures++; $display("FAIL %s_busy_len got=%0d exp=%0d", name, cyc, FRAME); end
    checks++;
    if (!early) begin failures++; $display("FAIL %s_ready_before_busy got=0 exp=1", name); end
    checks++;
    if (data_out !== exp_data || ready !== exp_ready) begin
      failures++;
      $display("FAIL %s_result got data_out=%h ready=%b exp data_out=%h ready=%b", name, data_out, ready, exp_data, exp_ready);
    end
  endtask

  task automatic test_clear();
    pulse_clear();
    checks++;
    if (ready !== exp_ready) begin failures++; $display("FAIL clear got ready=%b exp=%b", ready, exp_ready); end
    test_basic(8'h77, "clear_77");
  endtask

  task automatic test_ignore_busy();
    bit rose, early, seen; int cyc;
    send_frame(8'hA5, 1'b1, 8'h3C, 1'b0, rose, cyc, early, seen);
    checks++;
    if (cyc != FRAME) begin failures++; $display("FAIL ignore_busy_len got=%0d exp=%0d", cyc, FRAME); end
    checks++;
    if (data_out !== exp_data) begin failures++; $display("FAIL ignore_data got=%h exp=%h", data_out, exp_data); end
    rose = 1'b0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || data_out !== exp_data) rose = 1'b1;
    end
    checks++;
    if (rose) begin failures++; $display("FAIL ignore_no_second_frame got activity exp none (data_out=%h)", data_out); end
  endtask

  task automatic test_back_to_back();
    test_basic(8'h00, "b2b_00");
    test_basic(8'hFF, "b2b_FF");
  endtask

  task automatic test_reset_mid();
    bit bad; int cyc;
    @(negedge clk);
    data_in = 8'h5A; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0;
    checks++;
    if (dut.tx_line_s !== 1'b1 || busy !== 1'b0 || ready !== exp_ready || data_out !== exp_data) begin
      failures++;
      $display("FAIL reset_mid got tx=%b busy=%b ready=%b data_out=%h exp tx=1 busy=0 ready=0 data_out=00",
               dut.tx_line_s, busy, ready, data_out);
    end
    bad = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL reset_mid_no_update got ready=%b data_out=%h exp ready=0 data_out=00", ready, data_out); end
    test_basic(8'hC3, "after_reset_C3");
  endtask

  task automatic test_clear_collision();
    bit rose, early, seen; int cyc;
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b0, 8'h00, 1'b1, rose, cyc, early, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL collision_ready_set got=0 exp=1"); end
    checks++;
    if (data_out !== exp_data || ready !== exp_ready) begin
      failures++;
      $display("FAIL collision_result got data_out=%h ready=%b exp data_out=%h ready=%b", data_out, ready, exp_data, exp_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clear();
        checks++;
        if (ready !== exp_ready) begin failures++; $display("FAIL random_clear got ready=%b exp=%b", ready, exp_ready); end
      end
      test_basic(b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'h25, "basic_25");
    test_clear();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_clear_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
